// File: rtl/otn_link_pkg.sv
// -----------------------------------------------------------------------------
// otn_link_pkg
// Shared constants and helper functions for the OTN link emulator.
//   LFSR_W / LFSR_MASK : 8-bit Galois LFSR, right shift, taps 8'hB8 (period 255)
//   lfsr_next()        : one LFSR step
//   bitrev8()          : bit reversal, used only when OTN_ACK_DROP_EN is defined
//   DATA_IDLE/ACK_IDLE : idle line levels loaded into the delay lines at reset
// -----------------------------------------------------------------------------
package otn_link_pkg;

   localparam int               LFSR_W    = 8;
   localparam logic [LFSR_W-1:0] LFSR_MASK = 8'hB8;

   localparam logic DATA_IDLE = 1'b1;
   localparam logic ACK_IDLE  = 1'b0;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      logic [LFSR_W-1:0] nxt;
      nxt = cur >> 1;
      if (cur[0]) nxt = nxt ^ LFSR_MASK;
      return nxt;
   endfunction

   function automatic logic [LFSR_W-1:0] bitrev8(input logic [LFSR_W-1:0] v);
      logic [LFSR_W-1:0] r;
      for (int i = 0; i < LFSR_W; i++) r[i] = v[LFSR_W-1-i];
      return r;
   endfunction

endpackage

// File: rtl/otn_lfsr_chan.sv
// -----------------------------------------------------------------------------
// otn_lfsr_chan
// Per-channel corruption source: one 8-bit Galois LFSR plus the threshold
// compare that decides whether this cycle's forward bit is flipped.
// Optional macro OTN_ACK_DROP_EN adds o_ack_drop (compare on the bit-reversed
// LFSR value) for corrupting the reverse ACK path.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_seed_load      load i_corrupt_seed^CH (0 is replaced by 1) instead of stepping
//   i_corrupt_seed   seed value
//   i_corrupt_en     corruption enable for this channel
//   i_err_thresh     flip when lfsr < threshold
//   o_flip           combinational flip decision from the current LFSR state
//   o_ack_drop       (OTN_ACK_DROP_EN only) ACK drop decision
// -----------------------------------------------------------------------------
module otn_lfsr_chan
   import otn_link_pkg::*;
#(
   parameter int unsigned        CH        = 0,
   parameter logic [LFSR_W-1:0]  SEED_BASE = 8'hA5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_seed_load,
   input  logic [LFSR_W-1:0] i_corrupt_seed,
   input  logic              i_corrupt_en,
   input  logic [LFSR_W-1:0] i_err_thresh,
   output logic              o_flip
`ifdef OTN_ACK_DROP_EN
   ,
   output logic              o_ack_drop
`endif
);

   localparam logic [LFSR_W-1:0] CH_MASK = LFSR_W'(CH);
   localparam logic [LFSR_W-1:0] RST_VAL = SEED_BASE ^ CH_MASK;

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [LFSR_W-1:0] seeded;

   // The LFSR keeps running even when corruption is disabled, so every
   // channel's sequence stays a fixed function of cycle count and seed.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      seeded = i_corrupt_seed ^ CH_MASK;
      lfsr_d = lfsr_next(lfsr_q);
      if (i_seed_load) begin
         // An all-zero LFSR would lock up; substitute 1.
         lfsr_d = (seeded == '0) ? LFSR_W'(1) : seeded;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      if (!i_rst_n) lfsr_q <= RST_VAL;
      else          lfsr_q <= lfsr_d;
   end

   assign o_flip = i_corrupt_en && (lfsr_q < i_err_thresh);

`ifdef OTN_ACK_DROP_EN
   // Bit-reversed compare decorrelates ACK drops from data flips.
   assign o_ack_drop = i_corrupt_en && (bitrev8(lfsr_q) < i_err_thresh);
`endif

endmodule

// File: rtl/otn_link_emu.sv
// -----------------------------------------------------------------------------
// otn_link_emu
// Multi-channel serial link emulator placed between NUM_CH senders and
// receivers. Forward data: DELAY-cycle delay line with LFSR-driven bit flips
// and a saturating per-channel error counter. Reverse ACK: DELAY-cycle delay.
// Optional macro OTN_ACK_DROP_EN: ACK 1s are also randomly dropped (never
// created); drops are not counted.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_tx_data        serial data from sender c       -> o_rx_data to receiver c
//   i_rx_ack         ACK from receiver c             -> o_tx_ack to sender c
//   i_corrupt_en     per-channel corruption enable
//   i_err_thresh     flip probability threshold (flip when lfsr < thresh)
//   i_corrupt_seed   seed, loaded into all LFSRs on i_seed_load
//   i_cnt_clr        synchronous clear of all error counters (wins over a flip)
//   o_err_cnt        packed error counters, channel c at [c*CNT_W +: CNT_W]
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module otn_link_emu
   import otn_link_pkg::*;
#(
   parameter int                NUM_CH    = 2,
   parameter int                DELAY     = 4,
   parameter int                CNT_W     = 16,
   parameter logic [LFSR_W-1:0] SEED_BASE = 8'hA5
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_CH-1:0]         i_tx_data,
   output logic [NUM_CH-1:0]         o_rx_data,
   input  logic [NUM_CH-1:0]         i_rx_ack,
   output logic [NUM_CH-1:0]         o_tx_ack,
   input  logic [NUM_CH-1:0]         i_corrupt_en,
   input  logic [LFSR_W-1:0]         i_err_thresh,
   input  logic [LFSR_W-1:0]         i_corrupt_seed,
   input  logic                      i_seed_load,
   input  logic                      i_cnt_clr,
   output logic [NUM_CH*CNT_W-1:0]   o_err_cnt
);

   logic [NUM_CH-1:0] flip;
`ifdef OTN_ACK_DROP_EN
   logic [NUM_CH-1:0] ack_drop;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      otn_lfsr_chan #(
         .CH        (c),
         .SEED_BASE (SEED_BASE)
      ) u_lfsr (
         .i_clk          (i_clk),
         .i_rst_n        (i_rst_n),
         .i_seed_load    (i_seed_load),
         .i_corrupt_seed (i_corrupt_seed),
         .i_corrupt_en   (i_corrupt_en[c]),
         .i_err_thresh   (i_err_thresh),
         .o_flip         (flip[c])
`ifdef OTN_ACK_DROP_EN
         ,
         .o_ack_drop     (ack_drop[c])
`endif
      );
   end

   // Stage 0 is the input side; stage DELAY-1 drives the output.
   logic [NUM_CH-1:0][DELAY-1:0] data_sr_q, data_sr_d;
   logic [NUM_CH-1:0][DELAY-1:0] ack_sr_q,  ack_sr_d;
   logic [NUM_CH-1:0][CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      data_sr_d = data_sr_q;
      ack_sr_d  = ack_sr_q;
      err_cnt_d = err_cnt_q;
      for (int c = 0; c < NUM_CH; c++) begin
         data_sr_d[c][0] = i_tx_data[c] ^ flip[c];
`ifdef OTN_ACK_DROP_EN
         ack_sr_d[c][0]  = i_rx_ack[c] & ~ack_drop[c];
`else
         ack_sr_d[c][0]  = i_rx_ack[c];
`endif
         for (int s = 1; s < DELAY; s++) begin
            data_sr_d[c][s] = data_sr_q[c][s-1];
            ack_sr_d[c][s]  = ack_sr_q[c][s-1];
         end
         // Clear has priority; otherwise count flips and saturate at all-ones.
         if (i_cnt_clr) begin
            err_cnt_d[c] = '0;
         end else if (flip[c] && (err_cnt_q[c] != '1)) begin
            err_cnt_d[c] = err_cnt_q[c] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: the delay lines are reset (not left as bare storage) so the outputs show idle line levels at once.
         data_sr_q <= {(NUM_CH*DELAY){DATA_IDLE}};
         ack_sr_q  <= {(NUM_CH*DELAY){ACK_IDLE}};
         err_cnt_q <= '0;
      end else begin
         data_sr_q <= data_sr_d;
         ack_sr_q  <= ack_sr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      o_rx_data = '0;
      o_tx_ack  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         o_rx_data[c] = data_sr_q[c][DELAY-1];
         o_tx_ack[c]  = ack_sr_q[c][DELAY-1];
      end
   end

   assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_otn_link_emu.sv
// -----------------------------------------------------------------------------
// tb_otn_link_emu
// Directed bench for otn_link_emu (NUM_CH=2, DELAY=4). A second instance with
// CNT_W=4 shares the stimulus to exercise counter saturation. A small
// behavioural model of the link is stepped alongside the DUT each cycle.
// Honors OTN_ACK_DROP_EN when defined.
// -----------------------------------------------------------------------------
module tb_otn_link_emu;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] tx_data, rx_data, rx_ack, tx_ack, corrupt_en;
   logic [7:0] err_thresh, corrupt_seed;
   logic       seed_load, cnt_clr;
   logic [31:0] err_cnt;
   logic [1:0] rx4, ack4;
   logic [7:0] err_cnt4;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   otn_link_emu #(.NUM_CH(2), .DELAY(4), .CNT_W(16), .SEED_BASE(8'hA5)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_tx_data(tx_data), .o_rx_data(rx_data),
      .i_rx_ack(rx_ack), .o_tx_ack(tx_ack),
      .i_corrupt_en(corrupt_en), .i_err_thresh(err_thresh),
      .i_corrupt_seed(corrupt_seed), .i_seed_load(seed_load),
      .i_cnt_clr(cnt_clr), .o_err_cnt(err_cnt)
   );

   otn_link_emu #(.NUM_CH(2), .DELAY(4), .CNT_W(4), .SEED_BASE(8'hA5)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_tx_data(tx_data), .o_rx_data(rx4),
      .i_rx_ack(rx_ack), .o_tx_ack(ack4),
      .i_corrupt_en(corrupt_en), .i_err_thresh(err_thresh),
      .i_corrupt_seed(corrupt_seed), .i_seed_load(seed_load),
      .i_cnt_clr(cnt_clr), .o_err_cnt(err_cnt4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_lfsr [2];
   logic [3:0] m_dat  [2];
   logic [3:0] m_ack  [2];
   int         m_cnt  [2];
   int         m_cnt4 [2];

   function automatic logic [7:0] ref_next(input logic [7:0] v);
      logic [7:0] r;
      r = {1'b0, v[7:1]};
      if (v[0]) r = r ^ 8'hB8;
      return r;
   endfunction

   function automatic logic [7:0] ref_rev(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_lfsr[c] = 8'hA5 ^ 8'(c);
         m_dat[c]  = 4'hF;
         m_ack[c]  = 4'h0;
         m_cnt[c]  = 0;
         m_cnt4[c] = 0;
      end
   endtask

   // Advance model with the current inputs, clock the DUT, compare outputs.
   task automatic step();
      logic fl, dr;
      for (int c = 0; c < 2; c++) begin
         fl = corrupt_en[c] && (m_lfsr[c] < err_thresh);
         dr = 1'b0;
`ifdef OTN_ACK_DROP_EN
         dr = corrupt_en[c] && (ref_rev(m_lfsr[c]) < err_thresh);
`endif
         m_dat[c] = {m_dat[c][2:0], tx_data[c] ^ fl};
         m_ack[c] = {m_ack[c][2:0], rx_ack[c] & ~dr};
         if (cnt_clr) begin
            m_cnt[c]  = 0;
            m_cnt4[c] = 0;
         end else if (fl) begin
            if (m_cnt[c]  < 65535) m_cnt[c]++;
            if (m_cnt4[c] < 15)    m_cnt4[c]++;
         end
         if (seed_load) begin
            m_lfsr[c] = corrupt_seed ^ 8'(c);
            if (m_lfsr[c] == 8'h00) m_lfsr[c] = 8'h01;
         end else begin
            m_lfsr[c] = ref_next(m_lfsr[c]);
         end
      end
      @(posedge clk);
      #1;
      check("rx",   rx_data, {m_dat[1][3], m_dat[0][3]});
      check("ack",  tx_ack,  {m_ack[1][3], m_ack[0][3]});
      check("cnt",  err_cnt, {16'(m_cnt[1]), 16'(m_cnt[0])});
      check("rx4",  rx4,     {m_dat[1][3], m_dat[0][3]});
      check("ack4", ack4,    {m_ack[1][3], m_ack[0][3]});
      check("cnt4", err_cnt4, {4'(m_cnt4[1]), 4'(m_cnt4[0])});
   endtask

   task automatic set_idle();
      tx_data      = 2'b11;
      rx_ack       = 2'b00;
      corrupt_en   = 2'b00;
      err_thresh   = 8'h00;
      corrupt_seed = 8'h00;
      seed_load    = 1'b0;
      cnt_clr      = 1'b0;
   endtask

   // {ch1, ch0} per cycle: ch0 = 1,0,1,1,0 and ch1 = 0,1,1,0,0
   logic [1:0] t1_vec [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
   logic [1:0] hist [1000];
   int drops;

   initial begin
      set_idle();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      check("rst_rx",   rx_data,  2'b11);
      check("rst_ack",  tx_ack,   2'b00);
      check("rst_cnt",  err_cnt,  32'h0);
      check("rst_cnt4", err_cnt4, 8'h0);
      #10 rst_n = 1'b1;          // released mid-cycle
      model_reset();

      // ---- 1: corruption off, plain 4-cycle latency ----
      for (int i = 0; i < 8; i++) begin
         tx_data = (i < 5) ? t1_vec[i] : 2'b11;
         step();
         if (i < 3) check("t1_idle", rx_data, 2'b11);
         else       check("t1_seq",  rx_data, t1_vec[i-3]);
      end
      check("t1_cnt", err_cnt, 32'h0);

      // ---- seed 0 becomes 1; clear beats a simultaneous flip ----
      corrupt_en = 2'b01; err_thresh = 8'h02; corrupt_seed = 8'h00;
      seed_load = 1'b1; cnt_clr = 1'b1; tx_data = 2'b00;
      step();
      check("seed0_clr", err_cnt[15:0], 16'd0);
      seed_load = 1'b0; cnt_clr = 1'b0;
      step();                     // lfsr0 == 1 -> flip
      step();                     // lfsr0 == B8 -> no flip
      check("seed0_cnt0", err_cnt[15:0],  16'd1);
      check("seed0_cnt1", err_cnt[31:16], 16'd0);

      // ---- 2: full LFSR period with thresh 255 on ch0 ----
      corrupt_en = 2'b00; err_thresh = 8'hFF; corrupt_seed = 8'h01;
      seed_load = 1'b1; cnt_clr = 1'b1;
      step();
      seed_load = 1'b0; cnt_clr = 1'b0; corrupt_en = 2'b01;
      for (int i = 0; i < 255; i++) begin
         tx_data = 2'($urandom_range(0, 3));
         step();
      end
      check("t2_cnt_ch0", err_cnt[15:0],  16'd254);
      check("t2_cnt_ch1", err_cnt[31:16], 16'd0);

      // ---- 4: 4-bit counter saturation, clear on a flip cycle ----
      check("t4_sat", err_cnt4[3:0], 4'd15);
      cnt_clr = 1'b1;             // lfsr0 is back at 1: a flip cycle
      step();
      check("t4_clr4", err_cnt4[3:0], 4'd0);
      check("t4_clr",  err_cnt[15:0], 16'd0);
      cnt_clr = 1'b0;
      step();                     // lfsr0 == B8 -> flip
      check("t4_resume4", err_cnt4[3:0], 4'd1);
      check("t4_resume",  err_cnt[15:0], 16'd1);
      for (int i = 0; i < 20; i++) step();
      check("t4_hold", err_cnt4[3:0], 4'd15);

      // ---- 3: thresh 0 never flips ----
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0; err_thresh = 8'h00; corrupt_en = 2'b11;
      for (int i = 0; i < 1000; i++) begin
         tx_data = 2'($urandom_range(0, 3));
         hist[i] = tx_data;
         step();
         if (i >= 3) check("t3_delay", rx_data, hist[i-3]);
      end
      check("t3_cnt", err_cnt, 32'h0);

      // ---- 6: ACK held high with thresh 255 ----
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0; err_thresh = 8'hFF; corrupt_en = 2'b11; rx_ack = 2'b11;
      for (int i = 0; i < 4; i++) step();
      drops = 0;
      for (int i = 0; i < 40; i++) begin
         tx_data = 2'($urandom_range(0, 3));
         step();
         if (tx_ack != 2'b11) drops++;
      end
`ifdef OTN_ACK_DROP_EN
      check("t6_drops_seen", 64'(drops > 0), 64'd1);
`else
      check("t6_no_drop", 64'(drops), 64'd0);
`endif

      // ---- 5: asynchronous reset mid-stream ----
      tx_data = 2'b00;
      for (int i = 0; i < 8; i++) step();
      #3 rst_n = 1'b0;            // between clock edges
      #1;
      check("t5_rx",   rx_data,  2'b11);
      check("t5_ack",  tx_ack,   2'b00);
      check("t5_cnt",  err_cnt,  32'h0);
      check("t5_cnt4", err_cnt4, 8'h0);
      model_reset();
      set_idle();
      @(posedge clk);
      #4 rst_n = 1'b1;
      rx_ack = 2'b10;
      for (int k = 0; k < 6; k++) begin
         step();
         rx_ack = 2'b00;
         check("t5_ack_pulse", tx_ack, (k == 3) ? 2'b10 : 2'b00);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
